fetch_controller: RTL and testbench
===================================

# fetch_controller

Instruction-fetch sequencer between the instruction memory (combinational word-indexed ROM) and the decode stage. It owns the fetch PC and drives the ROM word address. It buffers fetched words with their PC+4 in a small FIFO and hands them to decode over a valid/ready handshake. It redirects on taken branches, flushes stale entries, and honours a global freeze.

## Interface
- `DEPTH`, 2: prefetch FIFO entries; power of two, 2..8.
- `RESET_PC`, 32'h0000_0000: byte address fetched first after reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  `WORD_WIDTH`  ROM word index; equals `{2'b00, fetch_pc[31:2]}`.
- `imem_instr`  in  `WORD_WIDTH`  ROM data for `imem_addr`, valid in the same cycle.
- `freeze`  in  1  global hazard stall.
- `branch_taken`  in  1  redirect request from execute.
- `branch_target`  in  `WORD_WIDTH`  redirect byte address; bits [1:0] are ignored.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instr`  out  `WORD_WIDTH`  head instruction.
- `out_pc4`  out  `WORD_WIDTH`  byte address of head + 4.
- `fetch_count`  out  `WORD_WIDTH`  number of words delivered to decode (handshakes), wraps.

## Operation
- Registers: `fetch_pc`, FIFO storage `{instr, pc4}` × DEPTH, read pointer, write pointer, occupancy count (0..DEPTH), and `fetch_count`.
- Pop: `out_valid && out_ready`. A pop is independent of `freeze`; freeze stops only fetching.
- Push condition: `!freeze && !branch_taken && (count < DEPTH || pop)`.
  - On push, `{imem_instr, fetch_pc+4}` is written at the write pointer.
  - `fetch_pc` advances by 4, modulo 2^32, so 32'hFFFF_FFFC → 0.
- Full with no pop: no push, and `fetch_pc` holds.
- Empty: `out_valid=0`. `out_instr` and `out_pc4` show stale storage and are don't-care.
- Redirect (`branch_taken=1`), which has priority over everything:
  - A pop in the same cycle still completes and `fetch_count` increments.
  - After the pop, all remaining entries are discarded: count←0, pointers←0.
  - `fetch_pc` ← `{branch_target[31:2], 2'b00}`; no push that cycle.
  - Redirect is honoured even while `freeze=1`.
- Simultaneous push and pop at `count==DEPTH`: allowed. Count is unchanged and both pointers advance mod DEPTH.
- Reset values: `fetch_pc`=RESET_PC, count=0, pointers=0, `fetch_count`=0, `out_valid`=0, `imem_addr`=RESET_PC>>2. FIFO storage is not reset.
- Reset asserted mid-operation discards all entries at the next edge, exactly as at power-up. `rst` overrides `branch_taken`.

## Timing
- `imem_addr` is a pure function of the `fetch_pc` register, so there is no combinational path from inputs.
- `out_*` come from registers and the read pointer only. There is no combinational path from `out_ready`, `branch_taken` or `freeze` to any output.
- Fetch latency: a word addressed in cycle N is visible on `out_instr` in cycle N+1.
- Redirect penalty:
  - `branch_taken` in cycle N → `imem_addr` = target in N+1.
  - `out_valid` = 0 in N+1, and the target instruction is at the head in N+2.
- After reset deassertion in cycle R: `out_valid` = 1 in R+1 with the word at RESET_PC.
- Steady state with `out_ready` held high: one instruction per cycle.

## Structure
- The shared header `constants.h` supplies `WORD_WIDTH`. Add `FETCH_PC_STEP` (=4) there.
- One sub-module: `fetch_fifo`.
  - Parameterised DEPTH × `2*WORD_WIDTH` synchronous FIFO.
  - Inputs: push, pop, flush. Outputs: full, empty, head.
  - Simultaneous push+pop is legal when full.
- `fetch_controller` holds the PC, the push/redirect logic and `fetch_count`.

## Test plan
- Reset, then `out_ready`=1 against the program ROM → cycle R+1: `out_valid`=1, `out_instr`=32'hE3A00014, `out_pc4`=4. Then one word per cycle; `fetch_count`=8 after 8 cycles.
- `out_ready`=0 for 5 cycles → count saturates at DEPTH=2 and `imem_addr` holds at 2. Releasing `out_ready` delivers words 0, 1, 2 in order with no gap or duplicate.
- `branch_taken`=1, `branch_target`=32'h70 in cycle N with a valid head popped → that head counts. `out_valid`=0 in N+1; `out_pc4`=32'h74 with `out_instr`=word 28 in N+2.
- `freeze`=1 for 3 cycles with `out_ready`=1 → FIFO drains to empty and `fetch_pc` holds. Deasserting `freeze` resumes at the held address.
- `RESET_PC`=32'hFFFF_FFF8 → PC sequence FFFF_FFF8, FFFF_FFFC, 0000_0000 and `out_pc4` wraps to 0.
- `rst` together with `branch_taken` while full → next cycle count=0, `out_valid`=0, `imem_addr`=RESET_PC>>2, `fetch_count`=0.

Source files
------------

// File: rtl/fetch_controller_pkg.sv
// fetch_controller_pkg: shared widths, PC step and FIFO entry layout for the fetch stage
package fetch_controller_pkg;
    localparam int WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] FETCH_PC_STEP = 32'd4;
    typedef struct packed {
        logic [WORD_WIDTH-1:0] instr;
        logic [WORD_WIDTH-1:0] pc4;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_controller_if.sv
// fetch_controller_if: ROM, redirect/freeze and decode handshake signals of the fetch stage
interface fetch_controller_if;
    import fetch_controller_pkg::*;
    logic [WORD_WIDTH-1:0] imem_addr;
    logic [WORD_WIDTH-1:0] imem_instr;
    logic                  freeze;
    logic                  branch_taken;
    logic [WORD_WIDTH-1:0] branch_target;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_WIDTH-1:0] out_instr;
    logic [WORD_WIDTH-1:0] out_pc4;
    logic [WORD_WIDTH-1:0] fetch_count;
    modport master (
        output imem_addr, out_valid, out_instr, out_pc4, fetch_count,
        input  imem_instr, freeze, branch_taken, branch_target, out_ready
    );
    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc4, fetch_count,
        output imem_instr, freeze, branch_taken, branch_target, out_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO with flush; push+pop is legal when full
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rp, wp;
    logic [CW-1:0] cnt;
    assign full  = cnt == CW'(DEPTH);
    assign empty = cnt == '0;
    assign head  = mem[rp];
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else begin
            rp  <= pop ? rp + AW'(1) : rp;
            wp  <= push ? wp + AW'(1) : wp;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
    // storage is deliberately left unreset
    always_ff @(posedge clk)
        if (push) mem[wp] <= din;
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: owns the fetch PC, fills the prefetch FIFO and handles redirect/freeze
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int                    DEPTH    = 2,
    parameter logic [WORD_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input logic                clk,
    input logic                rst,
    fetch_controller_if.master bus
);
    logic [WORD_WIDTH-1:0] pc, fc;
    fetch_entry_t          head;
    logic                  full, empty, pop, push;
    assign pop  = !empty && bus.out_ready;
    assign push = !bus.freeze && !bus.branch_taken && (!full || pop);
    assign bus.imem_addr   = {2'b00, pc[WORD_WIDTH-1:2]};
    assign bus.out_valid   = !empty;
    assign bus.out_instr   = head.instr;
    assign bus.out_pc4     = head.pc4;
    assign bus.fetch_count = fc;
    fetch_fifo #(.DEPTH(DEPTH), .W($bits(fetch_entry_t))) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .flush(bus.branch_taken),
        .din  ({bus.imem_instr, pc + FETCH_PC_STEP}),
        .full (full),
        .empty(empty),
        .head (head)
    );
    // a redirect still lets the same-cycle pop complete before the flush
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            fc <= '0;
        end else begin
            pc <= bus.branch_taken ? (bus.branch_target & ~WORD_WIDTH'(3)) :
                  push             ? pc + FETCH_PC_STEP : pc;
            fc <= pop ? fc + WORD_WIDTH'(1) : fc;
        end
    end
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed vector table, wrap sequence and random run against a queue model
module tb_fetch_controller;
    localparam int DEPTH = 2;
    localparam logic H = 1'b1, L = 1'b0;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'hE3A00014 : ((a * 32'h9E3779B1) ^ 32'h5A5A_0F0F);
    endfunction

    fetch_controller_if ifc();
    fetch_controller_if wi();
    assign ifc.imem_instr = rom_word(ifc.imem_addr);
    assign wi.imem_instr  = rom_word(wi.imem_addr);
    assign wi.freeze        = 1'b0;
    assign wi.branch_taken  = 1'b0;
    assign wi.branch_target = 32'h0;
    assign wi.out_ready     = 1'b1;

    fetch_controller #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst(rst), .bus(ifc));
    fetch_controller #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (.clk(clk), .rst(rst), .bus(wi));

    // behavioural model: a queue of {instr, pc4}, the fetch PC and a delivery counter
    logic [63:0] q[$];
    logic [31:0] mpc, mfc;
    logic        model_ok = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, rd, fz, br, input logic [31:0] tg);
        rst = r;
        ifc.out_ready = rd;
        ifc.freeze = fz;
        ifc.branch_taken = br;
        ifc.branch_target = tg;
        @(negedge clk);
        if (model_ok) begin
            chk("model_valid", 32'(ifc.out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("model_instr", ifc.out_instr, q[0][63:32]);
                chk("model_pc4", ifc.out_pc4, q[0][31:0]);
            end
            chk("model_addr", ifc.imem_addr, mpc >> 2);
            chk("model_count", ifc.fetch_count, mfc);
        end
    endtask

    task automatic advance();
        int n;
        logic p;
        @(posedge clk);
        if (rst) begin
            q.delete();
            mpc = 32'h0;
            mfc = 32'h0;
            model_ok = 1'b1;
        end else begin
            n = q.size();
            p = (n > 0) && ifc.out_ready;
            if (p) begin
                void'(q.pop_front());
                mfc = mfc + 1;
            end
            if (ifc.branch_taken) begin
                q.delete();
                mpc = ifc.branch_target & ~32'h3;
            end else if (!ifc.freeze && (n < DEPTH || p)) begin
                q.push_back({rom_word(mpc >> 2), mpc + 32'd4});
                mpc = mpc + 32'd4;
            end
        end
        #1;
    endtask

    typedef struct {
        logic        r, rd, fz, br;
        logic [31:0] tg;
        logic        ev;
        logic [31:0] epc4, eaddr, efc;
    } vec_t;
    vec_t tbl[26];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        tbl = '{
            '{H, H, L, L, 32'h0,  L, 32'h0,  32'd0,  32'd0},
            '{L, H, L, L, 32'h0,  L, 32'h0,  32'd0,  32'd0},
            '{L, H, L, L, 32'h0,  H, 32'd4,  32'd1,  32'd0},
            '{L, H, L, L, 32'h0,  H, 32'd8,  32'd2,  32'd1},
            '{L, H, L, L, 32'h0,  H, 32'd12, 32'd3,  32'd2},
            '{L, H, L, L, 32'h0,  H, 32'd16, 32'd4,  32'd3},
            '{L, H, L, L, 32'h0,  H, 32'd20, 32'd5,  32'd4},
            '{L, H, L, L, 32'h0,  H, 32'd24, 32'd6,  32'd5},
            '{L, H, L, L, 32'h0,  H, 32'd28, 32'd7,  32'd6},
            '{L, H, L, L, 32'h0,  H, 32'd32, 32'd8,  32'd7},
            '{L, L, L, L, 32'h0,  H, 32'd36, 32'd9,  32'd8},
            '{L, L, L, L, 32'h0,  H, 32'd36, 32'd10, 32'd8},
            '{L, L, L, L, 32'h0,  H, 32'd36, 32'd10, 32'd8},
            '{L, L, L, L, 32'h0,  H, 32'd36, 32'd10, 32'd8},
            '{L, L, L, L, 32'h0,  H, 32'd36, 32'd10, 32'd8},
            '{L, H, L, L, 32'h0,  H, 32'd36, 32'd10, 32'd8},
            '{L, H, L, L, 32'h0,  H, 32'd40, 32'd11, 32'd9},
            '{L, H, L, H, 32'h70, H, 32'd44, 32'd12, 32'd10},
            '{L, H, L, L, 32'h0,  L, 32'h0,  32'd28, 32'd11},
            '{L, H, H, L, 32'h0,  H, 32'h74, 32'd29, 32'd11},
            '{L, H, H, L, 32'h0,  L, 32'h0,  32'd29, 32'd12},
            '{L, H, H, L, 32'h0,  L, 32'h0,  32'd29, 32'd12},
            '{L, L, L, L, 32'h0,  L, 32'h0,  32'd29, 32'd12},
            '{L, L, L, L, 32'h0,  H, 32'h78, 32'd30, 32'd12},
            '{H, L, L, H, 32'h40, H, 32'h78, 32'd31, 32'd12},
            '{L, L, L, L, 32'h0,  L, 32'h0,  32'd0,  32'd0}
        };
        ifc.out_ready = 1'b1;
        ifc.freeze = 1'b0;
        ifc.branch_taken = 1'b0;
        ifc.branch_target = 32'h0;
        @(posedge clk);
        #1;
        advance();
        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].r, tbl[i].rd, tbl[i].fz, tbl[i].br, tbl[i].tg);
            chk($sformatf("vec%0d_valid", i), 32'(ifc.out_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_addr", i), ifc.imem_addr, tbl[i].eaddr);
            chk($sformatf("vec%0d_count", i), ifc.fetch_count, tbl[i].efc);
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_pc4", i), ifc.out_pc4, tbl[i].epc4);
                chk($sformatf("vec%0d_instr", i), ifc.out_instr, rom_word((tbl[i].epc4 - 32'd4) >> 2));
            end
            advance();
        end

        // PC wrap from 32'hFFFF_FFF8 on the second instance
        begin
            logic [31:0] wa[4], wp4[4];
            logic        wv[4];
            wa  = '{32'h3FFF_FFFE, 32'h3FFF_FFFF, 32'h0, 32'h1};
            wp4 = '{32'h0, 32'hFFFF_FFFC, 32'h0, 32'h4};
            wv  = '{L, H, H, H};
            drive(H, H, L, L, 32'h0);
            advance();
            for (int k = 0; k < 4; k++) begin
                drive(L, H, L, L, 32'h0);
                chk($sformatf("wrap%0d_addr", k), wi.imem_addr, wa[k]);
                chk($sformatf("wrap%0d_valid", k), 32'(wi.out_valid), 32'(wv[k]));
                if (wv[k]) begin
                    chk($sformatf("wrap%0d_pc4", k), wi.out_pc4, wp4[k]);
                    chk($sformatf("wrap%0d_instr", k), wi.out_instr, rom_word((wp4[k] - 32'd4) >> 2));
                end
                advance();
            end
        end

        for (int i = 0; i < 400; i++) begin
            drive(logic'($urandom_range(63) == 0), logic'($urandom_range(9) < 7),
                  logic'($urandom_range(4) == 0), logic'($urandom_range(9) == 0), $urandom);
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
